// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolutional encoder: preamble, DATA_LEN source bits, TAIL_LEN zero flush.
// Registered outputs, first bit one cycle after start; source bits reach enc_bit one cycle after src_rd; no backpressure.
module conv_frame_ctrl #(
    parameter int                  PRE_LEN     = 8,
    parameter logic [PRE_LEN-1:0]  PRE_PATTERN = 8'hA5,
    parameter int                  DATA_LEN    = 16,
    parameter int                  TAIL_LEN    = 2
) (
    input  logic       clk_sig,
    input  logic       rst_n,
    input  logic       start_p,
    input  logic       abort_p,
    input  logic       cont_sig,
    input  logic       src_bit,
    output logic       src_rd,
    output logic       enc_bit,
    output logic       enc_en,
    output logic [1:0] phase,
    output logic       busy,
    output logic       done_p
);
    localparam int MAX_PD = (PRE_LEN > DATA_LEN) ? PRE_LEN : DATA_LEN;
    localparam int MAX_L  = (MAX_PD > TAIL_LEN) ? MAX_PD : TAIL_LEN;
    localparam int CW     = $clog2(MAX_L + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_src_rd;
    logic               r_enc_bit;
    logic               r_enc_en;
    logic [1:0]         r_phase;
    logic               r_busy;
    logic               r_done;

    // r_cnt holds the index of the bit currently on enc_bit, counting down to 0 within a phase
    logic [CW-1:0]      w_pre_idx;
    logic [PRE_LEN-1:0] w_pre_sh;

    assign w_pre_idx = r_cnt - CW'(1);
    assign w_pre_sh  = PRE_PATTERN >> w_pre_idx;

    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_src_rd  <= 1'b0;
            r_enc_bit <= 1'b0;
            r_enc_en  <= 1'b0;
            r_phase   <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort_p) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_src_rd  <= 1'b0;
                r_enc_bit <= 1'b0;
                r_enc_en  <= 1'b0;
                r_phase   <= 2'd0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_p) begin
                            r_state   <= S_PRE;
                            r_cnt     <= CW'(PRE_LEN - 1);
                            r_enc_bit <= PRE_PATTERN[PRE_LEN-1];
                            r_enc_en  <= 1'b1;
                            r_phase   <= 2'd1;
                            r_busy    <= 1'b1;
                            r_src_rd  <= (PRE_LEN == 1);
                        end
                    end
                    S_PRE: begin
                        if (r_cnt == '0) begin
                            r_state   <= S_DATA;
                            r_cnt     <= CW'(DATA_LEN - 1);
                            r_enc_bit <= src_bit;
                            r_phase   <= 2'd2;
                            r_src_rd  <= (DATA_LEN != 1);
                        end else begin
                            r_cnt     <= w_pre_idx;
                            r_enc_bit <= w_pre_sh[0];
                            r_src_rd  <= (r_cnt == CW'(1));
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == '0) begin
                            r_state   <= S_TAIL;
                            r_cnt     <= CW'(TAIL_LEN - 1);
                            r_enc_bit <= 1'b0;
                            r_phase   <= 2'd3;
                            r_src_rd  <= 1'b0;
                        end else begin
                            r_cnt     <= r_cnt - CW'(1);
                            r_enc_bit <= src_bit;
                            r_src_rd  <= (r_cnt != CW'(1));
                        end
                    end
                    S_TAIL: begin
                        if (r_cnt == '0) begin
                            r_done <= 1'b1;
                            if (cont_sig) begin
                                r_state   <= S_PRE;
                                r_cnt     <= CW'(PRE_LEN - 1);
                                r_enc_bit <= PRE_PATTERN[PRE_LEN-1];
                                r_phase   <= 2'd1;
                                r_src_rd  <= (PRE_LEN == 1);
                            end else begin
                                r_state   <= S_IDLE;
                                r_enc_bit <= 1'b0;
                                r_enc_en  <= 1'b0;
                                r_phase   <= 2'd0;
                                r_busy    <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign src_rd  = r_src_rd;
    assign enc_bit = r_enc_bit;
    assign enc_en  = r_enc_en;
    assign phase   = r_phase;
    assign busy    = r_busy;
    assign done_p  = r_done;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Randomized bench for conv_frame_ctrl against a frame-position reference model.
module tb_conv_frame_ctrl;
    localparam int PRE_LEN  = 8;
    localparam int DATA_LEN = 16;
    localparam int TAIL_LEN = 2;
    localparam int N        = PRE_LEN + DATA_LEN + TAIL_LEN;

    logic       clk_sig = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_p = 1'b0;
    logic       abort_p = 1'b0;
    logic       cont_sig = 1'b0;
    logic       src_bit = 1'b0;
    logic       src_rd;
    logic       enc_bit;
    logic       enc_en;
    logic [1:0] phase;
    logic       busy;
    logic       done_p;

    conv_frame_ctrl #(
        .PRE_LEN(PRE_LEN), .PRE_PATTERN(8'hA5), .DATA_LEN(DATA_LEN), .TAIL_LEN(TAIL_LEN)
    ) dut (
        .clk_sig(clk_sig), .rst_n(rst_n), .start_p(start_p), .abort_p(abort_p),
        .cont_sig(cont_sig), .src_bit(src_bit), .src_rd(src_rd), .enc_bit(enc_bit),
        .enc_en(enc_en), .phase(phase), .busy(busy), .done_p(done_p)
    );

    always #5 clk_sig = ~clk_sig;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position within the frame of the bit shown (0 = idle) plus captured payload.
    logic [7:0] pre_pat = 8'hA5;
    int         pos = 0;
    logic       m_done = 1'b0;
    logic       cap [DATA_LEN];
    int         n_done = 0;
    int         n_en_low = 0;

    function automatic logic m_src_rd();
        return (pos >= PRE_LEN) && (pos <= PRE_LEN + DATA_LEN - 1);
    endfunction

    task automatic check_outputs();
        logic       e_bit;
        logic [1:0] e_ph;
        e_bit = 1'b0;
        e_ph  = 2'd0;
        if (pos >= 1 && pos <= PRE_LEN) begin
            e_bit = pre_pat[PRE_LEN - pos];
            e_ph  = 2'd1;
        end else if (pos > PRE_LEN && pos <= PRE_LEN + DATA_LEN) begin
            e_bit = cap[pos - PRE_LEN - 1];
            e_ph  = 2'd2;
        end else if (pos > PRE_LEN + DATA_LEN) begin
            e_ph  = 2'd3;
        end
        chk("enc_en",  32'(enc_en),  32'(pos > 0));
        chk("busy",    32'(busy),    32'(pos > 0));
        chk("enc_bit", 32'(enc_bit), 32'(e_bit));
        chk("phase",   32'(phase),   32'(e_ph));
        chk("src_rd",  32'(src_rd),  32'(m_src_rd()));
        chk("done_p",  32'(done_p),  32'(m_done));
        if (done_p) n_done++;
        if (!enc_en) n_en_low++;
    endtask

    task automatic model_step();
        if (m_src_rd()) cap[pos - PRE_LEN] = src_bit;
        m_done = 1'b0;
        if (abort_p) begin
            pos = 0;
        end else if (pos == 0) begin
            if (start_p) pos = 1;
        end else if (pos == N) begin
            m_done = 1'b1;
            pos = cont_sig ? 1 : 0;
        end else begin
            pos++;
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic c);
        @(posedge clk_sig);
        #1;
        start_p  = s;
        abort_p  = a;
        cont_sig = c;
        src_bit  = 1'($urandom_range(0, 1));
        @(negedge clk_sig);
        check_outputs();
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_sig);
        @(negedge clk_sig);
        chk("rst_en", 32'(enc_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_p), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        @(posedge clk_sig);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // Single frame; done pulse must fall at t=N+1 with idle afterwards
        n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        idle_cycles(N + 3);
        chk("single_done_cnt", 32'(n_done), 32'd1);

        // Continuous: three back-to-back frames, enable never drops
        cyc(1'b1, 1'b0, 1'b1);
        n_done = 0;
        n_en_low = 0;
        for (int i = 0; i < 3 * N - 1; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("cont_en_gaps", 32'(n_en_low), 32'd0);
        chk("cont_done_cnt", 32'(n_done), 32'd2);
        cyc(1'b0, 1'b0, 1'b0);
        idle_cycles(N + 2);

        // Abort at t=12, restart at t=14
        n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        idle_cycles(11);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("abort_en", 32'(enc_en), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("restart_msb", 32'(enc_bit), 32'd1);
        idle_cycles(N + 2);
        chk("abort_no_done", 32'(n_done), 32'd1);

        // Start while busy at t=5 ignored; start+abort in idle starts nothing
        cyc(1'b1, 1'b0, 1'b0);
        idle_cycles(4);
        cyc(1'b1, 1'b0, 1'b0);
        idle_cycles(N + 2);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("collide_idle", 32'(busy), 32'd0);

        // Reset mid-frame at t=10
        cyc(1'b1, 1'b0, 1'b0);
        idle_cycles(9);
        @(posedge clk_sig);
        #1 rst_n = 1'b0;
        start_p = 1'b0;
        abort_p = 1'b0;
        cont_sig = 1'b0;
        #1;
        chk("mid_rst_en", 32'(enc_en), 32'd0);
        chk("mid_rst_bit", 32'(enc_bit), 32'd0);
        chk("mid_rst_rd", 32'(src_rd), 32'd0);
        chk("mid_rst_phase", 32'(phase), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        pos = 0;
        m_done = 1'b0;
        @(posedge clk_sig);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        idle_cycles(N + 2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic s, a, c;
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 59) == 0);
            c = ($urandom_range(0, 1) == 0);
            cyc(s, a, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
